// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and colour codes for the display path.
// Imported by the timing controller and the picture stage.
package vga_timing_pkg;

    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 40;
    localparam int H_LEFT   = 8;
    localparam int H_VALID  = 640;
    localparam int H_RIGHT  = 8;
    localparam int H_FRONT  = 8;
    localparam int H_TOTAL  = H_SYNC + H_BACK + H_LEFT
                            + H_VALID + H_RIGHT + H_FRONT;

    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 25;
    localparam int V_TOP    = 8;
    localparam int V_VALID  = 480;
    localparam int V_BOTTOM = 8;
    localparam int V_FRONT  = 2;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_TOP
                            + V_VALID + V_BOTTOM + V_FRONT;

    localparam int HA = H_SYNC + H_BACK + H_LEFT;
    localparam int VA = V_SYNC + V_BACK + V_TOP;

    localparam logic [9:0] COORD_INV = 10'h3FF;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] GOLDEN = 16'hFEC0;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } coord_t;

    // Half-open window test: lo <= c < hi
    function automatic logic in_win(
        input logic [9:0] c,
        input logic [9:0] lo,
        input logic [9:0] hi
    );
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis counter: counts 0..MAX-1 while enabled, flags the wrap.
// Used for both the horizontal and the vertical axis.
module vga_axis_cnt #(
    parameter int MAX = 800
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       en_i,
    output logic [9:0] cnt_o,
    output logic       wrap_o
);

    localparam logic [9:0] LAST = 10'(MAX - 1);

    logic [9:0] cnt_q;
    logic [9:0] cnt_d;

    assign wrap_o = en_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (wrap_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster timing: sync, pixel request coordinates one clock
// ahead of the visible pixel, rgb gating and a frame-start strobe.
module vga_timing_ctrl #(
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BACK   = vga_timing_pkg::H_BACK,
    parameter int H_LEFT   = vga_timing_pkg::H_LEFT,
    parameter int H_VALID  = vga_timing_pkg::H_VALID,
    parameter int H_RIGHT  = vga_timing_pkg::H_RIGHT,
    parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BACK   = vga_timing_pkg::V_BACK,
    parameter int V_TOP    = vga_timing_pkg::V_TOP,
    parameter int V_VALID  = vga_timing_pkg::V_VALID,
    parameter int V_BOTTOM = vga_timing_pkg::V_BOTTOM,
    parameter int V_FRONT  = vga_timing_pkg::V_FRONT
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        frame_start
);

    import vga_timing_pkg::*;

    localparam int HT = H_SYNC + H_BACK + H_LEFT
                      + H_VALID + H_RIGHT + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_TOP
                      + V_VALID + V_BOTTOM + V_FRONT;
    localparam int HA_C = H_SYNC + H_BACK + H_LEFT;
    localparam int VA_C = V_SYNC + V_BACK + V_TOP;

    localparam logic [9:0] HS_W  = 10'(H_SYNC);
    localparam logic [9:0] VS_W  = 10'(V_SYNC);
    localparam logic [9:0] HA_W  = 10'(HA_C);
    localparam logic [9:0] HE_W  = 10'(HA_C + H_VALID);
    localparam logic [9:0] HRA_W = 10'(HA_C - 1);
    localparam logic [9:0] HRE_W = 10'(HA_C + H_VALID - 1);
    localparam logic [9:0] VA_W  = 10'(VA_C);
    localparam logic [9:0] VE_W  = 10'(VA_C + V_VALID);

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       h_wrap;
    logic       v_wrap;
    logic       v_win;
    logic       h_vis;
    logic       h_req;
    logic       pix_req;
    coord_t     req_xy;
    logic       fs_q;
    logic       fs_d;

    vga_axis_cnt #(.MAX(HT)) u_cnt_h (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .en_i      (1'b1),
        .cnt_o     (cnt_h),
        .wrap_o    (h_wrap)
    );

    vga_axis_cnt #(.MAX(VT)) u_cnt_v (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .en_i      (h_wrap),
        .cnt_o     (cnt_v),
        .wrap_o    (v_wrap)
    );

    assign v_win   = in_win(cnt_v, VA_W, VE_W);
    assign h_vis   = in_win(cnt_h, HA_W, HE_W);
    assign h_req   = in_win(cnt_h, HRA_W, HRE_W);
    assign pix_req = h_req && v_win;

    // Request window leads the visible window by the picture stage's register
    always_comb begin
        req_xy.x = COORD_INV;
        req_xy.y = COORD_INV;
        if (pix_req) begin
            req_xy.x = cnt_h - HRA_W;
            req_xy.y = cnt_v - VA_W;
        end
    end

    assign pix_x     = req_xy.x;
    assign pix_y     = req_xy.y;
    assign hsync     = cnt_h < HS_W;
    assign vsync     = cnt_v < VS_W;
    assign rgb_valid = h_vis && v_win;
    assign rgb       = rgb_valid ? pix_data : BLACK;

    // Vertical wrap implies horizontal wrap: next state is (0,0)
    assign fs_d = v_wrap;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fs_q <= 1'b1;
        end else begin
            fs_q <= fs_d;
        end
    end

    assign frame_start = fs_q;

endmodule
